fifo_unpacker: RTL

Downstream drain stage for the synchronous FIFO. It issues read strobes against the FIFO's registered read port and absorbs the FIFO read latency with a small word queue. Each DATA_WIDTH word is split into RATIO = DATA_WIDTH/OUT_WIDTH narrower lanes, which are presented on a valid/ready stream to the PE operand loaders. In steady state it sustains one output beat per cycle.

---
 rtl/fifo_unpacker_pkg.sv | 39 +++
 rtl/fifo_unpacker_if.sv | 30 +++
 rtl/unpack_word_q.sv | 72 +++++++
 rtl/fifo_unpacker.sv | 133 +++++++++++++
 4 files changed

// File: rtl/fifo_unpacker_pkg.sv
// fifo_unpacker_pkg: shared sizing helpers and constants for the FIFO unpacker.
//   calc_ratio  - lanes per FIFO word (DATA_WIDTH / OUT_WIDTH)
//   calc_qdepth - word-queue depth needed to absorb the FIFO read latency
//   ptr_w/cnt_w - pointer and occupancy widths for a queue of a given depth
//   cfg_ok      - elaboration-time legality check of the parameter set
//   LaneCntW    - width of the lane index / lane counter
package fifo_unpacker_pkg;

  // Lane counter width; bounds the supported RATIO to 2**LaneCntW.
  localparam int unsigned LaneCntW = 8;
  localparam int unsigned MaxRatio = 1 << LaneCntW;

  function automatic int unsigned calc_ratio(input int unsigned data_w,
                                             input int unsigned out_w);
    return data_w / out_w;
  endfunction

  // One entry per in-flight read plus the entry being drained.
  function automatic int unsigned calc_qdepth(input int unsigned rd_lat);
    return rd_lat + 1;
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit cfg_ok(input int unsigned data_w, input int unsigned out_w,
                                input int unsigned rd_lat);
    if (out_w == 0) return 1'b0;
    if ((data_w % out_w) != 0) return 1'b0;
    if ((data_w / out_w) > MaxRatio) return 1'b0;
    return (rd_lat == 1) || (rd_lat == 2);
  endfunction

endpackage

// File: rtl/fifo_unpacker_if.sv
// fifo_unpacker_if: FIFO read port, output stream and control of the unpacker.
//   master modport: the unpacker (drives fifo_rd_en/cs, m_valid/data/last, busy)
//   slave modport : the environment (FIFO, consumer, flush source)
interface fifo_unpacker_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned OUT_WIDTH  = 16
) ();

  logic                  flush;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd_en;
  logic                  fifo_rd_cs;
  logic                  m_valid;
  logic                  m_ready;
  logic [OUT_WIDTH-1:0]  m_data;
  logic                  m_last;
  logic                  busy;

  modport master (
    input  flush, fifo_empty, fifo_dout, m_ready,
    output fifo_rd_en, fifo_rd_cs, m_valid, m_data, m_last, busy
  );

  modport slave (
    output flush, fifo_empty, fifo_dout, m_ready,
    input  fifo_rd_en, fifo_rd_cs, m_valid, m_data, m_last, busy
  );

endinterface

// File: rtl/unpack_word_q.sv
// unpack_word_q: small circular word queue behind the FIFO read port.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers and storage)
//   clear_i    : synchronous drop of all entries; wins over push/pop
//   push_i     : write data_i at the tail
//   pop_i      : release the head entry
//   head_o     : head entry contents
//   occ_o      : number of entries held
//   empty_o    : occ_o == 0
module unpack_word_q
  import fifo_unpacker_pkg::*;
#(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear_i,
  input  logic                      push_i,
  input  logic [Width-1:0]          data_i,
  input  logic                      pop_i,
  output logic [Width-1:0]          head_o,
  output logic [cnt_w(Depth)-1:0]   occ_o,
  output logic                      empty_o
);

  localparam int unsigned PtrW = ptr_w(Depth);
  localparam int unsigned CntW = cnt_w(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  occ_q, occ_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      occ_d = occ_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      // Storage is cleared so the head (and thus m_data) reads zero out of reset.
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;
  assign empty_o = (occ_q == '0);

endmodule

// File: rtl/fifo_unpacker.sv
// fifo_unpacker: drains a synchronous FIFO with a registered read port and splits each
// DATA_WIDTH word into DATA_WIDTH/OUT_WIDTH lanes on a valid/ready stream.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fifo_unpacker_if.master
//                flush in, fifo_empty/fifo_dout in, fifo_rd_en/fifo_rd_cs out,
//                m_valid/m_data/m_last out, m_ready in, busy out
// Build option: define FIFO_UNPACKER_MSB_FIRST_EN to emit the most-significant lane first.
module fifo_unpacker
  import fifo_unpacker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned RD_LATENCY = 1
) (
  input logic            clk,
  input logic            rst_n,
  fifo_unpacker_if.master bus
);

  localparam int unsigned Ratio  = calc_ratio(DATA_WIDTH, OUT_WIDTH);
  localparam int unsigned QDepth = calc_qdepth(RD_LATENCY);
  localparam int unsigned CntW   = cnt_w(QDepth);

  if (!cfg_ok(DATA_WIDTH, OUT_WIDTH, RD_LATENCY)) begin : g_cfg_check
    $error("fifo_unpacker: illegal DATA_WIDTH/OUT_WIDTH/RD_LATENCY combination");
  end

  // Read tags: bit 0 is the read issued last cycle, the top bit is returning now.
  logic [RD_LATENCY-1:0] tag_q, tag_d;
  logic [RD_LATENCY-1:0] disc_q, disc_d;
  logic [CntW-1:0]       infl_q, infl_d;
  logic [LaneCntW-1:0]   lane_cnt_q, lane_cnt_d;

  logic [DATA_WIDTH-1:0] q_head;
  logic [CntW-1:0]       q_occ;
  logic                  q_empty;

  logic                  m_valid;
  logic                  lane_last;
  logic                  fire;
  logic                  pop;
  logic                  ret;
  logic                  push;
  logic                  rd_en;
  logic [CntW:0]         level;
  logic [LaneCntW-1:0]   lane_sel;
  logic [OUT_WIDTH-1:0]  m_data;

  assign m_valid   = !q_empty;
  assign lane_last = (lane_cnt_q == LaneCntW'(Ratio - 1));
  assign fire      = m_valid && bus.m_ready;
  assign pop       = fire && lane_last;
  assign ret       = tag_q[RD_LATENCY-1];
  assign push      = ret && !disc_q[RD_LATENCY-1] && !bus.flush;

  // Entries committed after this cycle; each in-flight read already owns a slot.
  assign level = {1'b0, q_occ} + {1'b0, infl_q} - (CntW + 1)'(pop);
  // rst_n gate keeps the strobe low during reset even though the FIFO may hold data.
  assign rd_en = rst_n && !bus.fifo_empty && !bus.flush && (level < (CntW + 1)'(QDepth));

  always_comb begin
    tag_d     = '0;
    disc_d    = '0;
    tag_d[0]  = rd_en;
    disc_d[0] = 1'b0;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_d[i]  = tag_q[i-1];
      // Everything still travelling at a flush edge is dropped when it lands.
      disc_d[i] = bus.flush ? tag_q[i-1] : disc_q[i-1];
    end
  end

  always_comb begin
    infl_d     = infl_q + CntW'(rd_en) - CntW'(ret);
    lane_cnt_d = lane_cnt_q;
    if (bus.flush) begin
      lane_cnt_d = '0;
    end else if (fire) begin
      lane_cnt_d = lane_last ? '0 : lane_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q      <= '0;
      disc_q     <= '0;
      infl_q     <= '0;
      lane_cnt_q <= '0;
    end else begin
      tag_q      <= tag_d;
      disc_q     <= disc_d;
      infl_q     <= infl_d;
      lane_cnt_q <= lane_cnt_d;
    end
  end

  unpack_word_q #(
    .Width (DATA_WIDTH),
    .Depth (QDepth)
  ) u_word_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (bus.flush),
    .push_i  (push),
    .data_i  (bus.fifo_dout),
    .pop_i   (pop),
    .head_o  (q_head),
    .occ_o   (q_occ),
    .empty_o (q_empty)
  );

`ifdef FIFO_UNPACKER_MSB_FIRST_EN
  assign lane_sel = LaneCntW'(Ratio - 1) - lane_cnt_q;
`else
  assign lane_sel = lane_cnt_q;
`endif

  always_comb begin
    m_data = '0;
    for (int k = 0; k < Ratio; k++) begin
      if (lane_sel == LaneCntW'(k)) m_data = q_head[k*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.fifo_rd_cs = rd_en;
  assign bus.m_valid    = m_valid;
  assign bus.m_data     = m_data;
  // Gated with m_valid so m_last reads zero when idle, including RATIO == 1.
  assign bus.m_last     = m_valid && lane_last;
  assign bus.busy       = (q_occ != '0) || (infl_q != '0);

endmodule
